// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
package spi_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Host-side command / TX / RX handshake bundle of the SPI sequencer.
interface spi_xfer_ctrl_if
    import spi_pkg::*;
#(
    parameter int unsigned CNT_W = 4
);

    logic              start;
    logic [CNT_W-1:0]  num_bytes;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              done;

    // Host logic (register file / FIFOs) side.
    modport master (
        output start, num_bytes, tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy, done
    );

    // Sequencer side.
    modport slave (
        input  start, num_bytes, tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, busy, done
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: sclk toggles every CLK_DIV enabled cycles, idles low.
// The strobes flag the cycle whose closing edge makes sclk rise or fall.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int unsigned       DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap;

    assign wrap     = en && (div_cnt == DIV_MAX);
    assign rise_stb = wrap && !sclk;
    assign fall_stb = wrap && sclk;

    // Half-period counter; disabling returns sclk low and restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master transaction sequencer, MSB first. Pulls TX bytes and
// pushes RX bytes over valid/ready handshakes, framing them with cs_n.
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    spi_xfer_ctrl_if.slave  bus,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
    output logic            cs_n
);

    localparam int unsigned WAIT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

    spi_state_e             state, state_d;
    logic [WAIT_W-1:0]      wait_cnt, wait_d;
    logic [BIT_CNT_W-1:0]   bit_cnt, bit_d;
    logic [CNT_W-1:0]       byte_cnt, byte_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [BYTE_W-1:0]      tx_sh, tx_sh_d;
    logic [BYTE_W-1:0]      rx_sh, rx_sh_d;
    logic [BYTE_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_en;
    logic                   rise_stb, fall_stb;
    logic [CNT_W-1:0]       byte_next;

    assign sclk_en   = (state == ST_SHIFT);
    assign byte_next = byte_cnt + CNT_W'(1);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (sclk_en),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // The TX shift register MSB is the line itself, so mosi is registered.
    assign mosi         = tx_sh[BYTE_W-1];
    assign cs_n         = cs_n_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_d;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            count_q    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            wait_cnt   <= wait_d;
            bit_cnt    <= bit_d;
            byte_cnt   <= byte_d;
            count_q    <= count_d;
            tx_sh      <= tx_sh_d;
            rx_sh      <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cs_n_q     <= cs_n_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        wait_d     = wait_cnt;
        bit_d      = bit_cnt;
        byte_d     = byte_cnt;
        count_d    = count_q;
        tx_sh_d    = tx_sh;
        rx_sh_d    = rx_sh;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cs_n_d     = cs_n_q;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.num_bytes == '0) begin
                        // Empty transaction: report completion without framing.
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        count_d = CNT_W'(bus.num_bytes);
                        byte_d  = '0;
                        bit_d   = '0;
                        wait_d  = '0;
                        busy_d  = 1'b1;
                        cs_n_d  = 1'b0;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (wait_cnt == WAIT_W'(CS_SETUP - 1)) begin
                    wait_d  = '0;
                    state_d = ST_LOAD;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end
            ST_LOAD: begin
                // Stalls here with sclk low while the host has no byte.
                if (bus.tx_valid && tx_ready_q) begin
                    tx_sh_d = bus.tx_data;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rise_stb) begin
                    rx_sh_d = {rx_sh[BYTE_W-2:0], miso};
                    bit_d   = bit_cnt + BIT_CNT_W'(1);
                end
                if (fall_stb) begin
                    // bit_cnt wraps to zero after the eighth rising edge.
                    if (bit_cnt == '0) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh;
                        byte_d     = byte_next;
                        wait_d     = '0;
                        state_d    = (byte_next == count_q) ? ST_HOLD : ST_LOAD;
                    end else begin
                        tx_sh_d = {tx_sh[BYTE_W-2:0], 1'b0};
                    end
                end
            end
            ST_HOLD: begin
                if (wait_cnt == WAIT_W'(CS_HOLD - 1)) begin
                    wait_d  = '0;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wait_d = wait_cnt + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_ready_d = (state_d == ST_LOAD);
    end

endmodule
